// File: rtl/qkv_proj_scheduler.sv
// qkv_proj_scheduler
// Runs the Q, K and V projection engines one after another so that they can
// share a single-port input-activation SRAM. On an accepted start the enabled
// engines are launched lowest index first. While an engine runs, its memory
// request is forwarded to the shared port. After each completion an idle gap
// is inserted before the next launch. A watchdog on each run flags a hung
// engine.
//
// Optional build macro: QKV_SCHED_PERF_EN adds per-engine RUN-cycle counters
// (perf_q, perf_k, perf_v).
//
// Ports
//   clk, rst_n                   clock, async active-low reset
//   start, eng_mask              batch request and engine selection
//   abort                        return to IDLE from any state
//   err_clr                      clear the sticky watchdog flag
//   busy, done                   status, one-cycle batch completion pulse
//   err, err_eng                 sticky timeout flag and offending engine
//   eng_en, eng_done             per-engine launch pulse / completion pulse
//   eng_mem_ceb/wen/addr         per-engine SRAM requests
//   INPUT_MEM_CEB/WEN/ADDR       shared SRAM port
//
// state  | meaning
// IDLE   | waiting for start
// PICK   | choose lowest remaining engine, or finish
// LAUNCH | one-cycle eng_en pulse, arm watchdog
// RUN    | engine owns the SRAM port, wait for its eng_done
// GAP    | idle cycles before the next pick
// DONE   | one-cycle done pulse
// ERR    | watchdog expired, port parked until err_clr or abort
module qkv_proj_scheduler #(
  parameter int N_ENG      = 3,
  parameter int ADDR_W     = 5,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            eng_mask,
  input  logic                  abort,
  input  logic                  err_clr,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_eng,
  output logic [2:0]            eng_en,
  input  logic [2:0]            eng_done,
  input  logic [2:0]            eng_mem_ceb,
  input  logic [2:0]            eng_mem_wen,
  input  logic [3*ADDR_W-1:0]   eng_mem_addr,
`ifdef QKV_SCHED_PERF_EN
  output logic [31:0]           perf_q,
  output logic [31:0]           perf_k,
  output logic [31:0]           perf_v,
`endif
  output logic                  INPUT_MEM_CEB,
  output logic                  INPUT_MEM_WEN,
  output logic [ADDR_W-1:0]     INPUT_MEM_ADDR
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LOAD   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_LAUNCH,
    S_RUN,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state;
  logic [1:0]      sel;
  logic [2:0]      mask_q;
  logic [TW-1:0]   timer;
  logic [GW-1:0]   gap_cnt;
  logic            sel_done;

  always_comb begin
    sel_done = 1'b0;
    case (sel)
      2'd0:    sel_done = eng_done[0];
      2'd1:    sel_done = eng_done[1];
      2'd2:    sel_done = eng_done[2];
      default: sel_done = 1'b0;
    endcase
  end

  // Watchdog is a down-counter loaded in LAUNCH; reaching zero in RUN means
  // this is the TIMEOUT-th RUN cycle without completion. Completion is tested
  // first so it wins a same-cycle tie with the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      sel     <= 2'd0;
      mask_q  <= 3'b000;
      timer   <= '0;
      gap_cnt <= '0;
      err     <= 1'b0;
      err_eng <= 2'd0;
    end else begin
      if (err_clr) err <= 1'b0;
      if (abort) begin
        state   <= S_IDLE;
        mask_q  <= 3'b000;
        timer   <= '0;
        gap_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              mask_q <= eng_mask;
              err    <= 1'b0;
              state  <= S_PICK;
            end
          end
          S_PICK: begin
            if (mask_q == 3'b000) begin
              state <= S_DONE;
            end else begin
              if (mask_q[0])      sel <= 2'd0;
              else if (mask_q[1]) sel <= 2'd1;
              else                sel <= 2'd2;
              mask_q <= mask_q & (mask_q - 3'd1);
              state  <= S_LAUNCH;
            end
          end
          S_LAUNCH: begin
            timer <= TIMER_LOAD;
            state <= S_RUN;
          end
          S_RUN: begin
            if (sel_done) begin
              if (GAP_CYCLES > 0) begin
                gap_cnt <= GAP_LOAD;
                state   <= S_GAP;
              end else begin
                state <= S_PICK;
              end
            end else if (timer == '0) begin
              err     <= 1'b1;
              err_eng <= sel;
              state   <= S_ERR;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          S_GAP: begin
            if (gap_cnt == '0) state <= S_PICK;
            else               gap_cnt <= gap_cnt - 1'b1;
          end
          S_DONE: state <= S_IDLE;
          S_ERR: begin
            if (err_clr) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);
  assign eng_en = (state == S_LAUNCH) ? (3'b001 << sel) : 3'b000;

  // Port is owned only in RUN; everywhere else it is parked (deselected).
  always_comb begin
    INPUT_MEM_CEB  = 1'b1;
    INPUT_MEM_WEN  = 1'b1;
    INPUT_MEM_ADDR = '0;
    if (state == S_RUN) begin
      case (sel)
        2'd0: begin
          INPUT_MEM_CEB  = eng_mem_ceb[0];
          INPUT_MEM_WEN  = eng_mem_wen[0];
          INPUT_MEM_ADDR = eng_mem_addr[0*ADDR_W +: ADDR_W];
        end
        2'd1: begin
          INPUT_MEM_CEB  = eng_mem_ceb[1];
          INPUT_MEM_WEN  = eng_mem_wen[1];
          INPUT_MEM_ADDR = eng_mem_addr[1*ADDR_W +: ADDR_W];
        end
        2'd2: begin
          INPUT_MEM_CEB  = eng_mem_ceb[2];
          INPUT_MEM_WEN  = eng_mem_wen[2];
          INPUT_MEM_ADDR = eng_mem_addr[2*ADDR_W +: ADDR_W];
        end
        default: begin
          INPUT_MEM_CEB  = 1'b1;
          INPUT_MEM_WEN  = 1'b1;
          INPUT_MEM_ADDR = '0;
        end
      endcase
    end
  end

`ifdef QKV_SCHED_PERF_EN
  // Counters hold after done/abort/ERR; only an accepted start clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= 32'd0;
      perf_k <= 32'd0;
      perf_v <= 32'd0;
    end else if (state == S_IDLE && start && !abort) begin
      perf_q <= 32'd0;
      perf_k <= 32'd0;
      perf_v <= 32'd0;
    end else if (state == S_RUN) begin
      case (sel)
        2'd0: if (perf_q != 32'hFFFF_FFFF) perf_q <= perf_q + 32'd1;
        2'd1: if (perf_k != 32'hFFFF_FFFF) perf_k <= perf_k + 32'd1;
        2'd2: if (perf_v != 32'hFFFF_FFFF) perf_v <= perf_v + 32'd1;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_qkv_proj_scheduler.sv
module tb_qkv_proj_scheduler;
  localparam int ADDR_W = 5;
  localparam int GAP    = 2;
  localparam int TMO    = 120;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, err_clr = 1'b0;
  logic [2:0] eng_mask = 3'b000, eng_done = 3'b000;
  logic [2:0] eng_mem_ceb = 3'b111, eng_mem_wen = 3'b111;
  logic [3*ADDR_W-1:0] eng_mem_addr = '0;
  logic busy, done, err;
  logic [1:0] err_eng;
  logic [2:0] eng_en;
  logic mem_ceb, mem_wen;
  logic [ADDR_W-1:0] mem_addr;
`ifdef QKV_SCHED_PERF_EN
  logic [31:0] perf_q, perf_k, perf_v;
`endif

  qkv_proj_scheduler #(.N_ENG(3), .ADDR_W(ADDR_W), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .eng_mask(eng_mask), .abort(abort),
    .err_clr(err_clr), .busy(busy), .done(done), .err(err), .err_eng(err_eng),
    .eng_en(eng_en), .eng_done(eng_done), .eng_mem_ceb(eng_mem_ceb),
    .eng_mem_wen(eng_mem_wen), .eng_mem_addr(eng_mem_addr),
`ifdef QKV_SCHED_PERF_EN
    .perf_q(perf_q), .perf_k(perf_k), .perf_v(perf_v),
`endif
    .INPUT_MEM_CEB(mem_ceb), .INPUT_MEM_WEN(mem_wen), .INPUT_MEM_ADDR(mem_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic timeout_fail(string nm);
    checks++;
    failures++;
    $display("FAIL %s cyc=%0d got=no-event expected=event", nm, cyc);
  endtask

  // reference model: batch timeline as timestamps
  bit  m_active, m_in_err, m_running, m_err;
  int  m_err_eng, m_cur, m_launch_at, m_done_at;
  int  m_q[$];
  longint m_perf[3];

  // event logs
  int en_cyc[$];
  int en_val[$];
  int done_cyc[$];
  int busy_cnt;
  int err_rise;
  bit prev_err;
  logic [2:0] en_last = 3'b000;

  // engine responders
  int  lat[3];
  int  cnt[3];
  bit  noise = 0;

  task automatic model_reset();
    m_active = 0; m_in_err = 0; m_running = 0; m_err = 0;
    m_err_eng = 0; m_cur = 0; m_launch_at = -1; m_done_at = -1;
    m_q.delete();
    for (int i = 0; i < 3; i++) m_perf[i] = 0;
  endtask

  task automatic model_step();
    int n;
    n = cyc;
    if (m_running && m_perf[m_cur] < 64'hFFFF_FFFF) m_perf[m_cur]++;
    if (err_clr) m_err = 0;
    if (abort) begin
      m_active = 0; m_in_err = 0; m_running = 0;
      m_launch_at = -1; m_done_at = -1; m_q.delete();
    end else if (m_in_err) begin
      if (err_clr) m_in_err = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_err = 0; m_q.delete();
        for (int i = 0; i < 3; i++) m_perf[i] = 0;
        for (int i = 0; i < 3; i++) if (eng_mask[i]) m_q.push_back(i);
        if (m_q.size() == 0) m_done_at = n + 2;
        else begin m_cur = m_q.pop_front(); m_launch_at = n + 2; end
      end
    end else begin
      if (n == m_done_at) begin
        m_active = 0; m_done_at = -1;
      end else if (n == m_launch_at) begin
        m_running = 1;
      end else if (m_running) begin
        if (eng_done[m_cur]) begin
          m_running = 0;
          if (m_q.size() > 0) begin m_cur = m_q.pop_front(); m_launch_at = n + GAP + 2; end
          else m_done_at = n + GAP + 2;
        end else if (n - m_launch_at == TMO) begin
          m_running = 0; m_active = 0; m_in_err = 1;
          m_err = 1; m_err_eng = m_cur;
        end
      end
    end
  endtask

  initial model_reset();

  always @(negedge clk) begin : cmp
    logic [2:0] e_en;
    logic e_done, e_busy, e_ceb, e_wen, e_err;
    logic [1:0] e_err_eng;
    logic [ADDR_W-1:0] e_addr;
    en_last = eng_en;
    if (!rst_n) model_reset();
    e_en = (m_launch_at == cyc) ? 3'(1 << m_cur) : 3'b000;
    e_done = (m_done_at == cyc);
    e_busy = m_active || m_in_err;
    e_err = m_err;
    e_err_eng = 2'(m_err_eng);
    if (m_running) begin
      e_ceb = eng_mem_ceb[m_cur];
      e_wen = eng_mem_wen[m_cur];
      e_addr = eng_mem_addr[m_cur*ADDR_W +: ADDR_W];
    end else begin
      e_ceb = 1'b1; e_wen = 1'b1; e_addr = '0;
    end
    chk("eng_en", eng_en, e_en);
    chk("done", done, e_done);
    chk("busy", busy, e_busy);
    chk("err", err, e_err);
    chk("err_eng", err_eng, e_err_eng);
    chk("mem_ceb", mem_ceb, e_ceb);
    chk("mem_wen", mem_wen, e_wen);
    chk("mem_addr", mem_addr, e_addr);
`ifdef QKV_SCHED_PERF_EN
    chk("perf_q", perf_q, m_perf[0]);
    chk("perf_k", perf_k, m_perf[1]);
    chk("perf_v", perf_v, m_perf[2]);
`endif
    if (eng_en != 3'b000) begin en_cyc.push_back(cyc); en_val.push_back(int'(eng_en)); end
    if (done) done_cyc.push_back(cyc);
    if (busy) busy_cnt++;
    if (err && !prev_err && err_rise < 0) err_rise = cyc;
    prev_err = err;
    if (rst_n) model_step();
  end

  task automatic clr_logs();
    en_cyc.delete(); en_val.delete(); done_cyc.delete();
    busy_cnt = 0; err_rise = -1;
  endtask

  task automatic clr_resp();
    for (int i = 0; i < 3; i++) cnt[i] = 0;
  endtask

  task automatic step(bit s = 0, logic [2:0] m = 3'b000, bit a = 0, bit ec = 0,
                      logic [2:0] fd = 3'b000);
    logic [2:0] d;
    @(posedge clk); #1;
    start = s;
    eng_mask = s ? m : 3'($urandom);
    abort = a;
    err_clr = ec;
    eng_mem_ceb = 3'($urandom);
    eng_mem_wen = 3'($urandom);
    eng_mem_addr = (3*ADDR_W)'($urandom);
    d = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (en_last[i] && lat[i] > 0) cnt[i] = lat[i];
      if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) d[i] = 1'b1;
      end
      if (noise && $urandom_range(0, 39) == 0) d[i] = 1'b1;
    end
    eng_done = d | fd;
  endtask

  task automatic wait_done(int want, int max);
    int k;
    k = 0;
    while (done_cyc.size() < want && k < max) begin step(); k++; end
    if (done_cyc.size() < want) timeout_fail("wait_done");
    step(); step();
  endtask

  task automatic wait_en(int want, int max);
    int k;
    k = 0;
    while (en_cyc.size() < want && k < max) begin step(); k++; end
    if (en_cyc.size() < want) timeout_fail("wait_en");
  endtask

  task automatic wait_err(int max);
    int k;
    k = 0;
    while (err_rise < 0 && k < max) begin step(); k++; end
    if (err_rise < 0) timeout_fail("wait_err");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    int s;
    for (int i = 0; i < 3; i++) begin lat[i] = 10; cnt[i] = 0; end
    clr_logs();
    rst_n = 1'b0;
    step(); step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_eng_en", eng_en, 3'b000);
    chk("rst_ceb", mem_ceb, 1'b1);
    chk("rst_wen", mem_wen, 1'b1);
    chk("rst_addr", mem_addr, '0);
    step();
    rst_n = 1'b1;
    step(); step();

    // all three engines, 100-cycle runs
    clr_logs(); lat = '{100, 100, 100};
    step(1, 3'b111); s = cyc;
    wait_done(1, 600);
    chk("t1_en_count", en_cyc.size(), 3);
    if (en_cyc.size() == 3 && done_cyc.size() == 1) begin
      chk("t1_first_en", en_cyc[0] - s, 2);
      chk("t1_en_q", en_val[0], 1);
      chk("t1_en_k", en_val[1], 2);
      chk("t1_en_v", en_val[2], 4);
      chk("t1_space_qk", en_cyc[1] - en_cyc[0], 104);
      chk("t1_space_kv", en_cyc[2] - en_cyc[1], 104);
      chk("t1_done_lat", done_cyc[0] - en_cyc[2], 104);
    end
    chk("t1_done_count", done_cyc.size(), 1);

    // Q and V only
    clr_logs(); lat = '{20, 20, 20};
    step(1, 3'b101);
    wait_done(1, 300);
    chk("t2_en_count", en_cyc.size(), 2);
    if (en_cyc.size() == 2) begin
      chk("t2_en_q", en_val[0], 1);
      chk("t2_en_v", en_val[1], 4);
    end

    // empty mask
    step(); clr_logs();
    step(1, 3'b000); s = cyc;
    repeat (4) step();
    chk("t3_done_count", done_cyc.size(), 1);
    if (done_cyc.size() == 1) chk("t3_done_cycle", done_cyc[0] - s, 2);
    chk("t3_no_en", en_cyc.size(), 0);
    chk("t3_busy_cycles", busy_cnt, 2);

    // hung K engine
    clr_logs(); lat = '{30, 0, 30};
    step(1, 3'b010);
    wait_err(400);
    if (en_cyc.size() == 1) chk("t4_err_lat", err_rise - en_cyc[0], TMO + 1);
    chk("t4_err", err, 1'b1);
    chk("t4_err_eng", err_eng, 2'd1);
    chk("t4_busy_err", busy, 1'b1);
    chk("t4_parked", mem_ceb, 1'b1);
    step(1, 3'b111);
    step();
    step(0, 3'b000, 0, 1);
    step();
    chk("t4_clr_err", err, 1'b0);
    chk("t4_clr_busy", busy, 1'b0);
    step();

    // completion on the terminal cycle wins
    clr_logs(); clr_resp(); lat = '{TMO, 0, 0};
    step(1, 3'b001);
    wait_done(1, 400);
    chk("t7_no_err", err_rise, -1);
    // one cycle late times out
    clr_logs(); lat = '{TMO + 1, 0, 0};
    step(1, 3'b001);
    wait_err(400);
    chk("t7_err_eng", err_eng, 2'd0);
    step(0, 3'b000, 1);
    step();
    chk("t7_err_sticky", err, 1'b1);
    chk("t7_idle", busy, 1'b0);
    step(1, 3'b000);
    step();
    chk("t7_start_clears", err, 1'b0);
    repeat (3) step();

    // abort mid-run, then K-only batch
    clr_logs(); clr_resp(); lat = '{100, 100, 100};
    step(1, 3'b111);
    wait_en(1, 10);
    repeat (10) step();
    step(0, 3'b000, 1);
    step();
    chk("t5_abort_idle", busy, 1'b0);
    repeat (3) step();
    chk("t5_no_done", done_cyc.size(), 0);
    clr_logs(); clr_resp(); lat = '{30, 30, 30};
    step(1, 3'b010);
    wait_done(1, 300);
    chk("t5_k_only_count", en_cyc.size(), 1);
    if (en_cyc.size() == 1) chk("t5_k_only", en_val[0], 2);

    // stray eng_done and start during RUN
    clr_logs(); lat = '{40, 40, 40};
    step(1, 3'b101);
    wait_en(1, 10);
    repeat (5) step();
    step(0, 3'b000, 0, 0, 3'b100);
    repeat (3) step();
    step(1, 3'b111);
    wait_done(1, 400);
    chk("t6_done_count", done_cyc.size(), 1);
    chk("t6_en_count", en_cyc.size(), 2);
    if (en_cyc.size() == 2) chk("t6_space", en_cyc[1] - en_cyc[0], 44);

    // reset mid-batch
    clr_logs(); lat = '{50, 50, 50};
    step(1, 3'b111);
    wait_en(1, 10);
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    chk("t8_rst_busy", busy, 1'b0);
    chk("t8_rst_ceb", mem_ceb, 1'b1);
    chk("t8_rst_addr", mem_addr, '0);
    step(); step();
    rst_n = 1'b1;
    clr_resp();
    step(); step();

    // randomized traffic
    noise = 1;
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < 3; i++)
        lat[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 60));
      step($urandom_range(0, 7) == 0, 3'($urandom), $urandom_range(0, 149) == 0,
           $urandom_range(0, 29) == 0);
    end
    noise = 0;
    step(0, 3'b000, 1, 1);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
